// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - reconstructs digit values and dp from a scanned common-anode 7-seg bus
module seg_scan_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int NUM_DIGITS    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [6:0]                seg_n,
  input  logic [NUM_DIGITS-1:0]     an_n,
  input  logic                      dp_n,
  input  logic                      clear,
  output logic [4*NUM_DIGITS-1:0]   digits,
  output logic [NUM_DIGITS-1:0]     dp_out,
  output logic [NUM_DIGITS-1:0]     valid,
  output logic [NUM_DIGITS-1:0]     err,
  output logic                      multi_an,
  output logic                      upd,
  output logic [2:0]                upd_idx
);

  localparam int SW = NUM_DIGITS + 8;

  logic [SW-1:0]         pins;
  logic [SW-1:0]         s_q;
  logic [7:0]            cnt;
  logic                  same;
  logic                  capture;
  logic [NUM_DIGITS-1:0] an_act;
  logic                  an_none;
  logic                  an_one;
  logic [2:0]            idx;
  logic [3:0]            code;
  logic                  code_ok;

  assign pins    = {an_n, seg_n, dp_n};
  assign same    = (pins == s_q);
  assign capture = same && (cnt == 8'(STABLE_CYCLES - 1));

  assign an_act  = ~an_n;
  assign an_none = (an_act == '0);
  // power-of-two test: clearing the lowest set bit leaves nothing
  assign an_one  = !an_none && ((an_act & (an_act - 1'b1)) == '0);

  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (an_act[i]) idx = 3'(i);
    end
  end

  always_comb begin
    code    = 4'h0;
    code_ok = 1'b1;
    case (seg_n)
      7'b0000001: code = 4'h0;
      7'b1001111: code = 4'h1;
      7'b0010010: code = 4'h2;
      7'b0000110: code = 4'h3;
      7'b1001100: code = 4'h4;
      7'b0100100: code = 4'h5;
      7'b1100000: code = 4'h6;
      7'b0001111: code = 4'h7;
      7'b0000000: code = 4'h8;
      7'b0001100: code = 4'h9;
      7'b1110010: code = 4'hA;
      7'b1100110: code = 4'hB;
      7'b1011100: code = 4'hC;
      7'b0110100: code = 4'hD;
      7'b1110000: code = 4'hE;
      7'b1111111: code = 4'hF;
      default:    code_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q      <= '1;
      cnt      <= '0;
      digits   <= '0;
      dp_out   <= '0;
      valid    <= '0;
      err      <= '0;
      multi_an <= 1'b0;
      upd      <= 1'b0;
      upd_idx  <= '0;
    end else begin
      s_q <= pins;
      upd <= 1'b0;
      if (!same)
        cnt <= '0;
      else if (cnt < 8'(STABLE_CYCLES))
        cnt <= cnt + 8'd1;

      if (capture && !an_none) begin
        if (!an_one) begin
          multi_an <= 1'b1;
        end else if (code_ok) begin
          digits[4*idx +: 4] <= code;
          dp_out[idx]        <= ~dp_n;
          valid[idx]         <= 1'b1;
          upd                <= 1'b1;
          upd_idx            <= idx;
        end else begin
          err[idx] <= 1'b1;
        end
      end

      // clear wins over same-cycle flag updates; data and upd still land
      if (clear) begin
        valid    <= '0;
        err      <= '0;
        multi_an <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - directed self-checking bench for seg_scan_decoder
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg_n;
  logic [7:0]  an_n;
  logic        dp_n;
  logic        clear;
  logic [31:0] digits;
  logic [7:0]  dp_out;
  logic [7:0]  valid;
  logic [7:0]  err;
  logic        multi_an;
  logic        upd;
  logic [2:0]  upd_idx;

  int checks = 0;
  int errors = 0;
  int upd_cnt = 0;
  int base;

  logic [6:0] seg_tab [0:7];

  seg_scan_decoder #(.STABLE_CYCLES(4), .NUM_DIGITS(8)) dut (
    .clk(clk), .rst(rst), .seg_n(seg_n), .an_n(an_n), .dp_n(dp_n),
    .clear(clear), .digits(digits), .dp_out(dp_out), .valid(valid),
    .err(err), .multi_an(multi_an), .upd(upd), .upd_idx(upd_idx)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (upd) upd_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [7:0] a, input logic [6:0] s, input logic d);
    an_n  = a;
    seg_n = s;
    dp_n  = d;
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    seg_tab[0] = 7'b0000001; seg_tab[1] = 7'b1001111;
    seg_tab[2] = 7'b0010010; seg_tab[3] = 7'b0000110;
    seg_tab[4] = 7'b1001100; seg_tab[5] = 7'b0100100;
    seg_tab[6] = 7'b1100000; seg_tab[7] = 7'b0001111;

    rst = 1'b1; clear = 1'b0;
    drive(8'hFF, 7'h7F, 1'b1);
    hold(3);
    rst = 1'b0;
    hold(1);
    check("rst_digits", digits, 32'h0);
    check("rst_flags", {dp_out, valid, err}, 24'h0);
    check("rst_misc", {multi_an, upd, upd_idx}, 5'h0);

    // single capture on digit 2, value 2, dp lit
    base = upd_cnt;
    drive(8'b11111011, 7'b0010010, 1'b0);
    hold(4);
    check("t1_no_early_upd", upd, 1'b0);
    hold(1);
    check("t1_upd", upd, 1'b1);
    check("t1_upd_idx", upd_idx, 3'd2);
    hold(1);
    check("t1_upd_pulse", upd, 1'b0);
    check("t1_digit", digits[11:8], 4'h2);
    check("t1_dp_out", dp_out, 8'b00000100);
    check("t1_valid", valid, 8'b00000100);
    check("t1_err", err, 8'h0);
    hold(14);
    check("t1_one_pulse", upd_cnt - base, 1);

    // dwell of only 4 edges is filtered out
    drive(8'hFF, 7'h7F, 1'b1);
    hold(2);
    base = upd_cnt;
    drive(8'b11110111, 7'b0100100, 1'b1);
    hold(4);
    drive(8'hFF, 7'h7F, 1'b1);
    hold(6);
    check("t2_no_upd", upd_cnt - base, 0);
    check("t2_valid", valid, 8'b00000100);
    check("t2_digit3", digits[15:12], 4'h0);

    // full scan of digits 0..7 with values 0..7
    base = upd_cnt;
    for (int d = 0; d < 8; d++) begin
      drive(~(8'h01 << d), seg_tab[d], 1'b1);
      hold(10);
      drive(8'hFF, 7'h7F, 1'b1);
      hold(2);
    end
    check("t3_upd_count", upd_cnt - base, 8);
    check("t3_digits", digits, 32'h76543210);
    check("t3_valid", valid, 8'hFF);
    check("t3_err", err, 8'h0);
    check("t3_multi", multi_an, 1'b0);
    check("t3_dp_out", dp_out, 8'h00);

    // undecodable pattern on digit 5
    base = upd_cnt;
    drive(8'b11011111, 7'b1010101, 1'b1);
    hold(10);
    drive(8'hFF, 7'h7F, 1'b1);
    hold(2);
    check("t4_err", err, 8'b00100000);
    check("t4_no_upd", upd_cnt - base, 0);
    check("t4_digit5", digits[23:20], 4'h5);

    // two anodes low
    base = upd_cnt;
    drive(8'b11111100, 7'b0000110, 1'b1);
    hold(10);
    check("t5_multi", multi_an, 1'b1);
    check("t5_no_upd", upd_cnt - base, 0);

    // clear coincides with capture of 1 on digit 0
    drive(8'b11111110, 7'b1001111, 1'b1);
    hold(4);
    clear = 1'b1;
    hold(1);
    clear = 1'b0;
    check("t5_clr_upd", upd, 1'b1);
    check("t5_clr_flags", {valid, err, 7'h0, multi_an}, 24'h0);
    check("t5_clr_digit0", digits[3:0], 4'h1);
    drive(8'hFF, 7'h7F, 1'b1);
    hold(2);

    // blank pattern decodes to F on digit 7
    drive(8'b01111111, 7'b1111111, 1'b1);
    hold(10);
    check("t6_digit7", digits[31:28], 4'hF);
    check("t6_valid", valid, 8'h80);

    // reset at edge 2 of a run on digit 4 showing 8, pins held through
    drive(8'b11101111, 7'b0000000, 1'b1);
    hold(2);
    rst = 1'b1;
    hold(1);
    rst = 1'b0;
    check("t6_rst_digits", digits, 32'h0);
    check("t6_rst_flags", {dp_out, valid, err, 7'h0, multi_an}, 32'h0);
    check("t6_rst_upd", {upd, upd_idx}, 4'h0);
    hold(4);
    check("t6_no_early", upd, 1'b0);
    hold(1);
    check("t6_upd", upd, 1'b1);
    check("t6_upd_idx", upd_idx, 3'd4);
    check("t6_digits", digits, 32'h00080000);
    check("t6_valid_after", valid, 8'h10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
